// File: rtl/mole_round_controller_if.sv
// mole_round_controller_if: game-round handshake between the sequencer and its player/display side
interface mole_round_controller_if;
  logic       i_start;
  logic       i_guess_valid;
  logic [2:0] i_user_guess;
  logic [2:0] o_mole_position;
  logic       o_mole_visible;
  logic       o_user_right;
  logic       o_user_wrong;
  logic       o_game_over;
  logic [7:0] o_score;
  logic [7:0] o_round;
  modport slave (
    input  i_start, i_guess_valid, i_user_guess,
    output o_mole_position, o_mole_visible, o_user_right, o_user_wrong, o_game_over, o_score, o_round
  );
  modport master (
    output i_start, i_guess_valid, i_user_guess,
    input  o_mole_position, o_mole_visible, o_user_right, o_user_wrong, o_game_over, o_score, o_round
  );
endinterface

// File: rtl/mole_round_controller.sv
// mole_round_controller: whack-a-mole round sequencer with LFSR spawn, judging, scoring and game-over
module mole_round_controller #(
  parameter int         ROUND_TICKS = 100000000,
  parameter int         GAP_TICKS   = 100000000,
  parameter int         NUM_ROUNDS  = 20,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input logic i_clk,
  input logic i_restart_game,
  mole_round_controller_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SPAWN, ACTIVE, GAP, OVER} state_t;
  localparam logic [27:0] ROUND_LAST = 28'(ROUND_TICKS - 1);
  localparam logic [27:0] GAP_LAST   = 28'(GAP_TICKS - 1);
  localparam logic [7:0]  LAST_ROUND = 8'(NUM_ROUNDS);
  state_t      state;
  logic [27:0] timer;
  logic [7:0]  lfsr;
  logic [2:0]  prev;
  logic [2:0]  cand;
  logic [2:0]  spawn_pos;
  assign cand      = lfsr[2:0];
  assign spawn_pos = (cand == prev) ? cand + 3'd1 : cand;
  always_ff @(posedge i_clk) begin
    if (i_restart_game) begin
      state               <= IDLE;
      timer               <= '0;
      lfsr                <= LFSR_SEED;
      prev                <= '0;
      bus.o_mole_position <= '0;
      bus.o_mole_visible  <= 1'b0;
      bus.o_user_right    <= 1'b0;
      bus.o_user_wrong    <= 1'b0;
      bus.o_game_over     <= 1'b0;
      bus.o_score         <= '0;
      bus.o_round         <= '0;
    end else begin
      // x^8+x^6+x^5+x^4+1, shifting toward the MSB
      lfsr             <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      bus.o_user_right <= 1'b0;
      bus.o_user_wrong <= 1'b0;
      case (state)
        IDLE: if (bus.i_start) begin
          bus.o_score <= '0;
          bus.o_round <= '0;
          timer       <= '0;
          state       <= SPAWN;
        end
        SPAWN: begin
          bus.o_mole_position <= spawn_pos;
          prev                <= spawn_pos;
          bus.o_round         <= bus.o_round + 8'd1;
          bus.o_mole_visible  <= 1'b1;
          timer               <= '0;
          state               <= ACTIVE;
        end
        ACTIVE: begin
          timer <= timer + 28'd1;
          // a guess landing on the timeout cycle wins over the timeout
          if (bus.i_guess_valid || timer == ROUND_LAST) begin
            bus.o_mole_visible <= 1'b0;
            timer              <= '0;
            state              <= GAP;
            if (bus.i_guess_valid && bus.i_user_guess == bus.o_mole_position) begin
              bus.o_user_right <= 1'b1;
              if (bus.o_score != 8'hFF) bus.o_score <= bus.o_score + 8'd1;
            end else begin
              bus.o_user_wrong <= 1'b1;
            end
          end
        end
        GAP: begin
          timer <= timer + 28'd1;
          if (timer == GAP_LAST) begin
            timer <= '0;
            if (bus.o_round == LAST_ROUND) begin
              bus.o_game_over <= 1'b1;
              state           <= OVER;
            end else begin
              state <= SPAWN;
            end
          end
        end
        OVER: state <= OVER;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mole_round_controller.sv
// tb_mole_round_controller: table-driven cycle checks of a 3-round game plus restart-mid-guess replay
module tb_mole_round_controller;
  localparam logic [7:0] SEED = 8'hA5;
  typedef struct {
    int rep;
    bit start, gv, right;
    bit vis, r, w, over;
    int score, round;
  } row_t;
  logic clk = 1'b0;
  logic restart;
  logic [7:0] m_lfsr, m_prev;
  logic [2:0] exp_pos, mprev, first_pos;
  bit pvis;
  int passed = 0;
  int total = 0;
  row_t rows[13];
  row_t replay_vis;
  mole_round_controller_if bus ();
  mole_round_controller #(.ROUND_TICKS(10), .GAP_TICKS(4), .NUM_ROUNDS(3), .LFSR_SEED(SEED)) dut (
    .i_clk(clk),
    .i_restart_game(restart),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    m_lfsr <= restart ? SEED : {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    m_prev <= m_lfsr;
  end
  task automatic check(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask
  task automatic check_outputs(bit vis, bit r, bit w, bit over, int score, int round, int pos);
    check("visible", int'(bus.o_mole_visible), int'(vis));
    check("user_right", int'(bus.o_user_right), int'(r));
    check("user_wrong", int'(bus.o_user_wrong), int'(w));
    check("game_over", int'(bus.o_game_over), int'(over));
    check("score", int'(bus.o_score), score);
    check("round", int'(bus.o_round), round);
    check("position", int'(bus.o_mole_position), pos);
  endtask
  task automatic run_row(row_t v);
    logic [2:0] cand, np;
    for (int k = 0; k < v.rep; k++) begin
      bus.i_start       = v.start;
      bus.i_guess_valid = v.gv;
      bus.i_user_guess  = v.right ? exp_pos : exp_pos + 3'd1;
      @(posedge clk);
      #1;
      bus.i_start       = 1'b0;
      bus.i_guess_valid = 1'b0;
      if (v.vis && !pvis) begin
        cand = m_prev[2:0];
        np   = (cand == mprev) ? cand + 3'd1 : cand;
        if (v.round > 1) check("pos_differs", int'(bus.o_mole_position != mprev), 1);
        exp_pos = np;
        mprev   = np;
      end
      pvis = v.vis;
      check_outputs(v.vis, v.r, v.w, v.over, v.score, v.round, int'(exp_pos));
    end
  endtask
  initial begin
    rows[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    rows[1]  = '{3, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    rows[2]  = '{1, 0, 1, 1, 0, 1, 0, 0, 1, 1};
    rows[3]  = '{4, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    rows[4]  = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 2};
    rows[5]  = '{1, 0, 1, 0, 0, 0, 1, 0, 1, 2};
    rows[6]  = '{1, 0, 1, 1, 0, 0, 0, 0, 1, 2};
    rows[7]  = '{3, 0, 0, 0, 0, 0, 0, 0, 1, 2};
    rows[8]  = '{10, 0, 0, 0, 1, 0, 0, 0, 1, 3};
    rows[9]  = '{1, 0, 0, 0, 0, 0, 1, 0, 1, 3};
    rows[10] = '{3, 0, 0, 0, 0, 0, 0, 0, 1, 3};
    rows[11] = '{1, 0, 0, 0, 0, 0, 0, 1, 1, 3};
    rows[12] = '{2, 1, 0, 0, 0, 0, 0, 1, 1, 3};
    replay_vis = '{2, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    restart = 1'b1;
    bus.i_start = 1'b0;
    bus.i_guess_valid = 1'b0;
    bus.i_user_guess = '0;
    exp_pos = '0;
    mprev = '0;
    pvis = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs(0, 0, 0, 0, 0, 0, 0);
    restart = 1'b0;
    for (int i = 0; i < 13; i++) begin
      run_row(rows[i]);
      if (i == 1) first_pos = exp_pos;
    end
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    check_outputs(0, 0, 0, 0, 0, 0, 0);
    exp_pos = '0;
    mprev = '0;
    pvis = 1'b0;
    run_row(rows[0]);
    run_row(replay_vis);
    bus.i_guess_valid = 1'b1;
    bus.i_user_guess  = exp_pos;
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    bus.i_guess_valid = 1'b0;
    check_outputs(0, 0, 0, 0, 0, 0, 0);
    exp_pos = '0;
    mprev = '0;
    pvis = 1'b0;
    run_row(rows[0]);
    run_row(rows[1]);
    check("replay_pos", int'(bus.o_mole_position), int'(first_pos));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
